// File: rtl/rca_multi_wb_ctrl.sv
// rca_multi_wb_ctrl
//   Writeback/commit controller for several concurrently running RCAs.
//   Each RCA channel has an in-order FIFO of in-flight use instructions
//   ({id, fb}). Channels whose FIFO head has a grid result ready are
//   round-robin arbitrated onto the single RCA writeback port. Config
//   instruction completions are merged onto the same port and take priority.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   issue_valid/_rca_sel/_id/_fb   push an RCA use instruction into a channel
//   issue_ready           per-channel FIFO not full (registered state only)
//   cfg_done_valid/_id    config instruction completion
//   grid_result_valid     per-channel head result ready
//   grid_result_data      per-channel result words, channel c at slice c
//   grid_pop              one-hot pop of the granted channel's output units
//   flush                 discard every in-flight RCA instruction
//   wb_done/_id/_fb/_rd   registered writeback, one cycle after grant/cfg
//   config_locked         some channel still has an instruction in flight
//   timeout_err           sticky per-channel watchdog flags
//
// Build option
//   RCA_WB_TIMEOUT_EN     enables the per-channel stall watchdog; without it
//                         timeout_err is tied to zero.

module rca_multi_wb_ctrl #(
    parameter int NUM_RCAS        = 4,
    parameter int DEPTH           = 4,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int XLEN            = 32,
    parameter int ID_W            = 3,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 issue_valid,
    input  logic [$clog2(NUM_RCAS)-1:0]          issue_rca_sel,
    input  logic [ID_W-1:0]                      issue_id,
    input  logic                                 issue_fb,
    output logic [NUM_RCAS-1:0]                  issue_ready,
    input  logic                                 cfg_done_valid,
    input  logic [ID_W-1:0]                      cfg_done_id,
    input  logic [NUM_RCAS-1:0]                  grid_result_valid,
    input  logic [NUM_RCAS*NUM_WRITE_PORTS*XLEN-1:0] grid_result_data,
    output logic [NUM_RCAS-1:0]                  grid_pop,
    input  logic                                 flush,
    output logic                                 wb_done,
    output logic [ID_W-1:0]                      wb_id,
    output logic                                 wb_fb,
    output logic [NUM_WRITE_PORTS*XLEN-1:0]      wb_rd,
    output logic                                 config_locked,
    output logic [NUM_RCAS-1:0]                  timeout_err
);

    localparam int SEL_W = $clog2(NUM_RCAS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RD_W  = NUM_WRITE_PORTS * XLEN;

    if (NUM_RCAS < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("rca_multi_wb_ctrl: illegal parameterisation");
    end

    // Offset from the round-robin pointer, wrapped into the channel range.
    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_RCAS) s = s - NUM_RCAS;
        return SEL_W'(s);
    endfunction

    logic [ID_W:0]         ent_mem [NUM_RCAS][DEPTH];
    logic [PTR_W-1:0]      wr_ptr  [NUM_RCAS];
    logic [PTR_W-1:0]      rd_ptr  [NUM_RCAS];
    logic [CNT_W-1:0]      cnt     [NUM_RCAS];
    logic [SEL_W-1:0]      rr_ptr;

    logic [NUM_RCAS-1:0]   nempty, full;
    logic [NUM_RCAS-1:0]   cand_p0, push_p0, pop_p0;
    logic                  gnt_vld_p0;
    logic [SEL_W-1:0]      gnt_p0;
    logic [ID_W:0]         head_p0;
    logic [RD_W-1:0]       rd_sel_p0;

    logic                  vld_p1;
    logic [ID_W-1:0]       id_p1;
    logic                  fb_p1;
    logic [RD_W-1:0]       rd_p1;

    // ---- stage p0: candidates, arbitration, FIFO push/pop ----
    always_comb begin
        nempty  = '0;
        full    = '0;
        cand_p0 = '0;
        push_p0 = '0;
        for (int c = 0; c < NUM_RCAS; c++) begin
            nempty[c]  = (cnt[c] != '0);
            full[c]    = (cnt[c] == CNT_W'(DEPTH));
            cand_p0[c] = nempty[c] && grid_result_valid[c];
            // Readiness comes from registered occupancy, so a same-cycle pop
            // never makes room for a push.
            push_p0[c] = issue_valid && !flush && !full[c] && (issue_rca_sel == SEL_W'(c));
        end
    end

    // Config completions and flush both block the RCA grant.
    always_comb begin
        gnt_vld_p0 = 1'b0;
        gnt_p0     = '0;
        if (!cfg_done_valid && !flush) begin
            for (int i = 0; i < NUM_RCAS; i++) begin
                if (!gnt_vld_p0 && cand_p0[rr_idx(rr_ptr, i)]) begin
                    gnt_vld_p0 = 1'b1;
                    gnt_p0     = rr_idx(rr_ptr, i);
                end
            end
        end
    end

    always_comb begin
        pop_p0    = '0;
        head_p0   = '0;
        rd_sel_p0 = '0;
        for (int c = 0; c < NUM_RCAS; c++) begin
            if (gnt_vld_p0 && gnt_p0 == SEL_W'(c)) begin
                pop_p0[c] = 1'b1;
                head_p0   = ent_mem[c][rd_ptr[c]];
                rd_sel_p0 = grid_result_data[c*RD_W +: RD_W];
            end
        end
    end

    assign grid_pop    = pop_p0;
    assign issue_ready = ~full;
    assign config_locked = |nempty;

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_RCAS; c++) begin
            if (push_p0[c]) ent_mem[c][wr_ptr[c]] <= {issue_id, issue_fb};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            for (int c = 0; c < NUM_RCAS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
        end else begin
            if (gnt_vld_p0)
                rr_ptr <= (gnt_p0 == SEL_W'(NUM_RCAS - 1)) ? '0 : gnt_p0 + SEL_W'(1);
            for (int c = 0; c < NUM_RCAS; c++) begin
                if (flush) begin
                    wr_ptr[c] <= '0;
                    rd_ptr[c] <= '0;
                    cnt[c]    <= '0;
                end else begin
                    if (push_p0[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                    if (pop_p0[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
                    case ({push_p0[c], pop_p0[c]})
                        2'b10:   cnt[c] <= cnt[c] + CNT_W'(1);
                        2'b01:   cnt[c] <= cnt[c] - CNT_W'(1);
                        default: cnt[c] <= cnt[c];
                    endcase
                end
            end
        end
    end

    // ---- stage p1: registered writeback ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            id_p1  <= '0;
            fb_p1  <= 1'b0;
            rd_p1  <= '0;
        end else if (cfg_done_valid) begin
            vld_p1 <= 1'b1;
            id_p1  <= cfg_done_id;
            fb_p1  <= 1'b0;
            rd_p1  <= '0;
        end else if (gnt_vld_p0) begin
            vld_p1 <= 1'b1;
            id_p1  <= head_p0[ID_W:1];
            fb_p1  <= head_p0[0];
            rd_p1  <= rd_sel_p0;
        end else begin
            vld_p1 <= 1'b0;
            fb_p1  <= 1'b0;
            rd_p1  <= '0;
        end
    end

    assign wb_done = vld_p1;
    assign wb_id   = id_p1;
    assign wb_fb   = fb_p1;
    assign wb_rd   = rd_p1;

`ifdef RCA_WB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCNT_W-1:0]   tcnt [NUM_RCAS];
    logic [NUM_RCAS-1:0] terr;

    // Counts stalled cycles (head waiting, no result); saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            terr <= '0;
            for (int c = 0; c < NUM_RCAS; c++) tcnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_RCAS; c++) begin
                if (flush) begin
                    tcnt[c] <= '0;
                    terr[c] <= 1'b0;
                end else if (pop_p0[c]) begin
                    tcnt[c] <= '0;
                end else if (nempty[c] && !grid_result_valid[c] &&
                             tcnt[c] != TCNT_W'(TIMEOUT_CYCLES)) begin
                    tcnt[c] <= tcnt[c] + TCNT_W'(1);
                    if (tcnt[c] == TCNT_W'(TIMEOUT_CYCLES - 1)) terr[c] <= 1'b1;
                end
            end
        end
    end

    assign timeout_err = terr;
`else
    assign timeout_err = '0;
`endif

endmodule
